// File: rtl/connect4_board_renderer.sv
// Connect-4 pixel colour stage: draws board, cursor disc and falling-disc animation
// behind a fixed 3-cycle pipeline with syncs delayed to match.
module connect4_board_renderer #(
    parameter int X0        = 96,
    parameter int Y0        = 80,
    parameter int R2        = 784,
    parameter int DROP_STEP = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       display_en,
    input  logic       hsync_in,
    input  logic       vsync_in,
    output logic [5:0] board_addr,
    input  logic [1:0] board_data,
    input  logic [2:0] cursor_col,
    input  logic       cur_player,
    input  logic       drop_start,
    input  logic [2:0] drop_col,
    input  logic [2:0] drop_row,
    input  logic       drop_player,
    output logic       drop_busy,
    output logic       drop_done,
    output logic [2:0] vga_r,
    output logic [2:0] vga_g,
    output logic [1:0] vga_b,
    output logic       hsync_out,
    output logic       vsync_out
);

    typedef enum logic {IDLE, FALL} state_t;

    localparam logic [7:0] COL_RED    = 8'b111_000_00;
    localparam logic [7:0] COL_YELLOW = 8'b111_111_00;
    localparam logic [7:0] COL_BLUE   = 8'b000_000_11;

    // The 12-bit sum keeps the 32,32 corner (2048) from wrapping into the disc.
    function automatic logic disc_hit(input logic [5:0] ox, input logic [5:0] oy);
        logic [5:0]  ax;
        logic [5:0]  ay;
        logic [11:0] sum;
        ax  = ox[5] ? {1'b0, ox[4:0]} : 6'd32 - ox;
        ay  = oy[5] ? {1'b0, oy[4:0]} : 6'd32 - oy;
        sum = {6'd0, ax} * {6'd0, ax} + {6'd0, ay} * {6'd0, ay};
        return sum < 12'(R2);
    endfunction

    state_t     state_q, state_d;
    logic [9:0] anim_y_q, anim_y_d;
    logic [9:0] target_q, target_d;
    logic [2:0] dcol_q, dcol_d;
    logic       dplayer_q, dplayer_d;
    logic       done_q, done_d;
    logic       frame_tick;
    logic [10:0] step_y;

    logic [10:0] rx, ry, ay_anim;
    logic        rx_ok, in_board, in_strip;
    logic [2:0]  col, row;

    logic [5:0] board_addr_q, board_addr_d;
    logic [5:0] s1_off_x_q, s1_off_x_d;
    logic [5:0] s1_off_y_q, s1_off_y_d;
    logic [5:0] s1_aoff_y_q, s1_aoff_y_d;
    logic       s1_board_q, s1_board_d;
    logic       s1_strip_q, s1_strip_d;
    logic       s1_cur_col_q, s1_cur_col_d;
    logic       s1_anim_row_q, s1_anim_row_d;
    logic       s1_cplayer_q, s1_cplayer_d;
    logic       s1_dplayer_q, s1_dplayer_d;
    logic       s1_de_q, s1_de_d;
    logic       s1_hs_q, s1_hs_d;
    logic       s1_vs_q, s1_vs_d;

    logic       s2_disc_q, s2_disc_d;
    logic       s2_anim_q, s2_anim_d;
    logic       s2_cursor_q, s2_cursor_d;
    logic       s2_board_q, s2_board_d;
    logic       s2_cplayer_q, s2_cplayer_d;
    logic       s2_dplayer_q, s2_dplayer_d;
    logic       s2_de_q, s2_de_d;
    logic       s2_hs_q, s2_hs_d;
    logic       s2_vs_q, s2_vs_d;

    logic [7:0] rgb_q, rgb_d;
    logic       s3_hs_q, s3_hs_d;
    logic       s3_vs_q, s3_vs_d;

    assign drop_busy  = (state_q == FALL);
    assign drop_done  = done_q;
    assign board_addr = board_addr_q;
    assign vga_r      = rgb_q[7:5];
    assign vga_g      = rgb_q[4:2];
    assign vga_b      = rgb_q[1:0];
    assign hsync_out  = s3_hs_q;
    assign vsync_out  = s3_vs_q;

    // The vsync copies already in the pipeline double as the edge detector.
    always_comb begin
        state_d    = state_q;
        anim_y_d   = anim_y_q;
        target_d   = target_q;
        dcol_d     = dcol_q;
        dplayer_d  = dplayer_q;
        done_d     = 1'b0;
        frame_tick = s2_vs_q && !s1_vs_q;
        step_y     = {1'b0, anim_y_q} + 11'(DROP_STEP);
        case (state_q)
            IDLE: begin
                if (drop_start && drop_col <= 3'd6 && drop_row <= 3'd5) begin
                    dcol_d    = drop_col;
                    dplayer_d = drop_player;
                    target_d  = 10'(Y0) + {1'b0, drop_row, 6'd0};
                    anim_y_d  = 10'(Y0 - 64);
                    state_d   = FALL;
                end
            end
            FALL: begin
                if (frame_tick) begin
                    if (anim_y_q == target_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else if (step_y >= {1'b0, target_q}) begin
                        anim_y_d = target_q;
                    end else begin
                        anim_y_d = step_y[9:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rx       = {1'b0, pixel_x} - 11'(X0);
        ry       = {1'b0, pixel_y} - 11'(Y0);
        ay_anim  = {1'b0, pixel_y} - {1'b0, anim_y_q};
        rx_ok    = !rx[10] && (rx < 11'd448);
        in_board = rx_ok && !ry[10] && (ry < 11'd384);
        in_strip = rx_ok && ry[10] && (ry >= 11'h7C0);
        col      = rx[8:6];
        row      = ry[8:6];

        board_addr_d  = in_board ? (6'(row) * 6'd7 + 6'(col)) : 6'd0;
        s1_off_x_d    = rx[5:0];
        s1_off_y_d    = ry[5:0];
        s1_aoff_y_d   = ay_anim[5:0];
        s1_board_d    = in_board;
        s1_strip_d    = in_strip;
        s1_cur_col_d  = (col == cursor_col);
        s1_anim_row_d = drop_busy && rx_ok && (col == dcol_q) && (ay_anim[10:6] == 5'd0);
        s1_cplayer_d  = cur_player;
        s1_dplayer_d  = dplayer_q;
        s1_de_d       = display_en;
        s1_hs_d       = hsync_in;
        s1_vs_d       = vsync_in;

        s2_disc_d    = disc_hit(s1_off_x_q, s1_off_y_q);
        s2_anim_d    = s1_anim_row_q && disc_hit(s1_off_x_q, s1_aoff_y_q);
        s2_cursor_d  = s1_strip_q && s1_cur_col_q;
        s2_board_d   = s1_board_q;
        s2_cplayer_d = s1_cplayer_q;
        s2_dplayer_d = s1_dplayer_q;
        s2_de_d      = s1_de_q;
        s2_hs_d      = s1_hs_q;
        s2_vs_d      = s1_vs_q;
    end

    // board_data arrives alongside the stage-2 registers, so colour select reads it directly.
    always_comb begin
        rgb_d   = 8'h00;
        s3_hs_d = s2_hs_q;
        s3_vs_d = s2_vs_q;
        if (s2_de_q) begin
            if (s2_anim_q) begin
                rgb_d = s2_dplayer_q ? COL_YELLOW : COL_RED;
            end else if (s2_cursor_q && s2_disc_q) begin
                rgb_d = s2_cplayer_q ? COL_YELLOW : COL_RED;
            end else if (s2_board_q && !s2_disc_q) begin
                rgb_d = COL_BLUE;
            end else if (s2_board_q) begin
                case (board_data)
                    2'b01:   rgb_d = COL_RED;
                    2'b10:   rgb_d = COL_YELLOW;
                    default: rgb_d = 8'h00;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            anim_y_q      <= 10'd0;
            target_q      <= 10'd0;
            dcol_q        <= 3'd0;
            dplayer_q     <= 1'b0;
            done_q        <= 1'b0;
            board_addr_q  <= 6'd0;
            s1_off_x_q    <= 6'd0;
            s1_off_y_q    <= 6'd0;
            s1_aoff_y_q   <= 6'd0;
            s1_board_q    <= 1'b0;
            s1_strip_q    <= 1'b0;
            s1_cur_col_q  <= 1'b0;
            s1_anim_row_q <= 1'b0;
            s1_cplayer_q  <= 1'b0;
            s1_dplayer_q  <= 1'b0;
            s1_de_q       <= 1'b0;
            s1_hs_q       <= 1'b1;
            s1_vs_q       <= 1'b1;
            s2_disc_q     <= 1'b0;
            s2_anim_q     <= 1'b0;
            s2_cursor_q   <= 1'b0;
            s2_board_q    <= 1'b0;
            s2_cplayer_q  <= 1'b0;
            s2_dplayer_q  <= 1'b0;
            s2_de_q       <= 1'b0;
            s2_hs_q       <= 1'b1;
            s2_vs_q       <= 1'b1;
            rgb_q         <= 8'h00;
            s3_hs_q       <= 1'b1;
            s3_vs_q       <= 1'b1;
        end else begin
            state_q       <= state_d;
            anim_y_q      <= anim_y_d;
            target_q      <= target_d;
            dcol_q        <= dcol_d;
            dplayer_q     <= dplayer_d;
            done_q        <= done_d;
            board_addr_q  <= board_addr_d;
            s1_off_x_q    <= s1_off_x_d;
            s1_off_y_q    <= s1_off_y_d;
            s1_aoff_y_q   <= s1_aoff_y_d;
            s1_board_q    <= s1_board_d;
            s1_strip_q    <= s1_strip_d;
            s1_cur_col_q  <= s1_cur_col_d;
            s1_anim_row_q <= s1_anim_row_d;
            s1_cplayer_q  <= s1_cplayer_d;
            s1_dplayer_q  <= s1_dplayer_d;
            s1_de_q       <= s1_de_d;
            s1_hs_q       <= s1_hs_d;
            s1_vs_q       <= s1_vs_d;
            s2_disc_q     <= s2_disc_d;
            s2_anim_q     <= s2_anim_d;
            s2_cursor_q   <= s2_cursor_d;
            s2_board_q    <= s2_board_d;
            s2_cplayer_q  <= s2_cplayer_d;
            s2_dplayer_q  <= s2_dplayer_d;
            s2_de_q       <= s2_de_d;
            s2_hs_q       <= s2_hs_d;
            s2_vs_q       <= s2_vs_d;
            rgb_q         <= rgb_d;
            s3_hs_q       <= s3_hs_d;
            s3_vs_q       <= s3_vs_d;
        end
    end

endmodule

// File: tb/tb_connect4_board_renderer.sv
// Self-checking bench for connect4_board_renderer: directed board/cursor/sync cases,
// randomized pixel streams against a geometric reference model, and drop animation timing.
module tb_connect4_board_renderer;

    localparam logic [7:0] RED  = 8'b111_000_00;
    localparam logic [7:0] YEL  = 8'b111_111_00;
    localparam logic [7:0] BLUE = 8'b000_000_11;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] pixel_x, pixel_y;
    logic       display_en, hsync_in, vsync_in;
    logic [5:0] board_addr;
    logic [1:0] board_data;
    logic [2:0] cursor_col;
    logic       cur_player, drop_start;
    logic [2:0] drop_col, drop_row;
    logic       drop_player, drop_busy, drop_done;
    logic [2:0] vga_r, vga_g;
    logic [1:0] vga_b;
    logic       hsync_out, vsync_out;

    int checks = 0;
    int errors = 0;

    logic [1:0] boardMem [0:63];

    // Reference model of the animation, tracked at the level of game rules.
    bit mBusy = 1'b0;
    int mAnimY = 0;
    int mTarget = 0;
    int mDcol = 0;
    bit mDplayer = 1'b0;

    connect4_board_renderer dut (
        .clk(clk), .rst(rst),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .display_en(display_en),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .board_addr(board_addr), .board_data(board_data),
        .cursor_col(cursor_col), .cur_player(cur_player),
        .drop_start(drop_start), .drop_col(drop_col), .drop_row(drop_row),
        .drop_player(drop_player), .drop_busy(drop_busy), .drop_done(drop_done),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .hsync_out(hsync_out), .vsync_out(vsync_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) board_data <= boardMem[board_addr];

    function automatic logic [7:0] rgbOut();
        return {vga_r, vga_g, vga_b};
    endfunction

    function automatic bit inCircle(input int dx, input int dy);
        return (dx * dx + dy * dy) < 784;
    endfunction

    function automatic logic [7:0] expColour(input int px, input int py, input bit de);
        int rx, ry, col, ay;
        bit rxOk;
        if (!de) return 8'h00;
        rx = px - 96;
        ry = py - 80;
        rxOk = (rx >= 0) && (rx < 448);
        col = rxOk ? rx / 64 : -1;
        ay = py - mAnimY;
        if (mBusy && rxOk && col == mDcol && ay >= 0 && ay < 64 && inCircle(rx % 64 - 32, ay - 32))
            return mDplayer ? YEL : RED;
        if (rxOk && ry >= -64 && ry < 0 && col == int'(cursor_col) && inCircle(rx % 64 - 32, ry + 32))
            return cur_player ? YEL : RED;
        if (rxOk && ry >= 0 && ry < 384) begin
            if (!inCircle(rx % 64 - 32, ry % 64 - 32)) return BLUE;
            case (boardMem[(ry / 64) * 7 + col])
                2'b01:   return RED;
                2'b10:   return YEL;
                default: return 8'h00;
            endcase
        end
        return 8'h00;
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int px, input int py, input bit de, input bit hs, input bit vs);
        pixel_x    = 10'(px);
        pixel_y    = 10'(py);
        display_en = de;
        hsync_in   = hs;
        vsync_in   = vs;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_rgb"}, 16'(rgbOut()), 16'h0000);
        checkOutput({tag, "_hsync"}, 16'(hsync_out), 16'h0001);
        checkOutput({tag, "_vsync"}, 16'(vsync_out), 16'h0001);
        checkOutput({tag, "_busy"}, 16'(drop_busy), 16'h0000);
        checkOutput({tag, "_done"}, 16'(drop_done), 16'h0000);
        checkOutput({tag, "_addr"}, 16'(board_addr), 16'h0000);
    endtask

    task automatic checkPixel(input string tag, input int px, input int py, input bit de,
                              input logic [7:0] exp);
        int rx, ry;
        @(posedge clk); #1;
        applyStimulus(px, py, de, 1'b1, 1'b1);
        rx = px - 96;
        ry = py - 80;
        @(posedge clk); #1;
        if (rx >= 0 && rx < 448 && ry >= 0 && ry < 384)
            checkOutput({tag, "_addr"}, 16'(board_addr), 16'((ry / 64) * 7 + rx / 64));
        repeat (2) @(posedge clk);
        #1;
        checkOutput(tag, 16'(rgbOut()), 16'(exp));
    endtask

    task automatic streamPixels(input int n, input bit focus);
        logic [7:0] qRgb[$];
        bit qHs[$];
        bit qVs[$];
        int px, py;
        bit de, hs, vs;
        for (int i = 0; i < n + 3; i++) begin
            @(posedge clk); #1;
            if (i >= 3) begin
                checkOutput("stream_rgb", 16'(rgbOut()), 16'(qRgb.pop_front()));
                checkOutput("stream_hsync", 16'(hsync_out), 16'(qHs.pop_front()));
                checkOutput("stream_vsync", 16'(vsync_out), 16'(qVs.pop_front()));
            end
            if (i < n) begin
                if (focus && $urandom_range(0, 1) == 1) begin
                    px = 96 + mDcol * 64 + int'($urandom_range(0, 63));
                    py = mAnimY + int'($urandom_range(0, 63));
                end else if ($urandom_range(0, 3) == 0) begin
                    px = int'($urandom_range(0, 639));
                    py = int'($urandom_range(0, 479));
                end else begin
                    px = int'($urandom_range(90, 550));
                    py = int'($urandom_range(10, 470));
                end
                de = ($urandom_range(0, 7) != 0);
                hs = ($urandom_range(0, 3) != 0);
                vs = mBusy ? 1'b1 : ($urandom_range(0, 3) != 0);
                applyStimulus(px, py, de, hs, vs);
                qRgb.push_back(expColour(px, py, de));
                qHs.push_back(hs);
                qVs.push_back(vs);
            end else begin
                applyStimulus(0, 0, 1'b0, 1'b1, 1'b1);
            end
        end
    endtask

    task automatic dropRequest(input int col, input int row, input bit player);
        @(posedge clk); #1;
        drop_start  = 1'b1;
        drop_col    = 3'(col);
        drop_row    = 3'(row);
        drop_player = player;
        @(posedge clk); #1;
        drop_start = 1'b0;
        if (!mBusy && col <= 6 && row <= 5) begin
            mBusy    = 1'b1;
            mDcol    = col;
            mDplayer = player;
            mTarget  = 80 + 64 * row;
            mAnimY   = 16;
        end
    endtask

    // One vsync low pulse; counts drop_done pulses seen and advances the model.
    task automatic frameTick(output int doneSeen, output int doneExp);
        doneSeen = 0;
        doneExp  = 0;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            if (drop_done) doneSeen++;
            vsync_in = (i >= 3);
        end
        if (mBusy) begin
            if (mAnimY == mTarget) begin
                doneExp = 1;
                mBusy   = 1'b0;
            end else begin
                mAnimY = (mAnimY + 8 > mTarget) ? mTarget : mAnimY + 8;
            end
        end
    endtask

    initial begin
        int seen, expd, total, guard;
        bit hsPat[0:19];
        bit vsPat[0:19];

        rst = 1'b1;
        applyStimulus(0, 0, 1'b0, 1'b1, 1'b1);
        cursor_col  = 3'd0;
        cur_player  = 1'b0;
        drop_start  = 1'b0;
        drop_col    = 3'd0;
        drop_row    = 3'd0;
        drop_player = 1'b0;
        for (int i = 0; i < 64; i++) boardMem[i] = 2'($urandom_range(0, 3));
        boardMem[0] = 2'b01;

        repeat (4) @(posedge clk);
        #1;
        checkResetState("reset");
        rst = 1'b0;

        $display("[TB] directed pixels");
        checkPixel("hole_corner_br", 543, 463, 1'b1, BLUE);
        checkPixel("board_red", 128, 112, 1'b1, RED);
        checkPixel("hole_corner_tl", 96, 80, 1'b1, BLUE);
        checkPixel("right_of_board", 544, 200, 1'b1, 8'h00);
        checkPixel("de_low", 128, 112, 1'b0, 8'h00);
        cursor_col = 3'd3;
        cur_player = 1'b1;
        checkPixel("cursor_yellow", 320, 48, 1'b1, YEL);
        cursor_col = 3'd7;
        checkPixel("cursor_none", 320, 48, 1'b1, 8'h00);

        $display("[TB] sync alignment");
        for (int i = 0; i < 20; i++) begin
            hsPat[i] = !(i >= 3 && i <= 6);
            vsPat[i] = !(i >= 5 && i <= 11);
        end
        for (int i = 0; i < 23; i++) begin
            @(posedge clk); #1;
            if (i >= 3) begin
                checkOutput("sync_hsync", 16'(hsync_out), 16'(hsPat[i - 3]));
                checkOutput("sync_vsync", 16'(vsync_out), 16'(vsPat[i - 3]));
            end
            if (i < 20) applyStimulus(0, 0, 1'b0, hsPat[i], vsPat[i]);
            else applyStimulus(0, 0, 1'b0, 1'b1, 1'b1);
        end

        $display("[TB] random pixel streams");
        for (int k = 0; k < 4; k++) begin
            cursor_col = 3'($urandom_range(0, 7));
            cur_player = 1'($urandom_range(0, 1));
            streamPixels(150, 1'b0);
        end

        $display("[TB] drop animation");
        dropRequest(2, 6, 1'b0);
        checkOutput("drop_row_range", 16'(drop_busy), 16'(mBusy));
        dropRequest(7, 0, 1'b0);
        checkOutput("drop_col_range", 16'(drop_busy), 16'(mBusy));
        dropRequest(2, 5, 1'b1);
        checkOutput("drop_busy_start", 16'(drop_busy), 16'(mBusy));
        for (int t = 0; t < 5; t++) begin
            frameTick(seen, expd);
            checkOutput("drop_done_tick", 16'(seen), 16'(expd));
        end
        cursor_col = 3'd2;
        streamPixels(150, 1'b1);
        dropRequest(5, 0, 1'b0);
        checkOutput("drop_ignored_busy", 16'(drop_busy), 16'(mBusy));
        streamPixels(100, 1'b1);
        guard = 0;
        while (mBusy && guard < 60) begin
            frameTick(seen, expd);
            checkOutput("drop_done_tick", 16'(seen), 16'(expd));
            if (mBusy && mAnimY == mTarget && guard > 40) streamPixels(60, 1'b1);
            guard++;
        end
        checkOutput("drop_busy_end", 16'(drop_busy), 16'(mBusy));
        checkOutput("drop_done_end", 16'(drop_done), 16'h0000);

        $display("[TB] reset mid-animation");
        dropRequest(4, 3, 1'b0);
        checkOutput("drop2_busy", 16'(drop_busy), 16'(mBusy));
        for (int t = 0; t < 10; t++) begin
            frameTick(seen, expd);
            checkOutput("drop2_done_tick", 16'(seen), 16'(expd));
        end
        @(posedge clk); #1;
        applyStimulus(320, 300, 1'b1, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkResetState("midreset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mBusy = 1'b0;
        applyStimulus(0, 0, 1'b0, 1'b1, 1'b1);
        total = 0;
        for (int t = 0; t < 15; t++) begin
            frameTick(seen, expd);
            total += seen;
        end
        checkOutput("midreset_no_done", 16'(total), 16'h0000);
        checkOutput("midreset_busy", 16'(drop_busy), 16'h0000);
        streamPixels(80, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
